countdown_timer: RTL and testbench

- Three-stage cascaded down-counter: the count-down counterpart to the team's cascaded stopwatch counter. Same q0/q1/q2 digit layout.
- Loaded with a start value, decrements once per prescaled tick while enabled, stops at zero and reports expiry.
- Drives the same display/readout path as the stopwatch, so q0..q2 keep identical width and digit meaning (q0 least significant).

---
 rtl/countdown_pkg.sv | 16 +
 rtl/countdown_timer_down_stage.sv | 28 ++
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the cascaded countdown timer.
package countdown_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_W   = 7;
  localparam int DEF_MOD = 10;

  // Out-of-range digits are pinned to the largest legal digit.
  function automatic int unsigned clamp_mod(int unsigned d, int unsigned m);
    return (d >= m) ? m - 1 : d;
  endfunction
endpackage

// File: rtl/countdown_timer_down_stage.sv
// One mod-MOD down-counting digit; o_borrow is combinational so stages can chain.
module down_stage
  import countdown_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int MOD = DEF_MOD
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_dec,
  output logic [W-1:0] o_q,
  output logic         o_borrow,
  output logic         o_is_zero
);
  logic [W-1:0] r_q;

  assign o_q       = r_q;
  assign o_is_zero = (r_q == '0);
  assign o_borrow  = i_dec && o_is_zero && !i_load;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_q <= '0;
    else if (i_load) r_q <= W'(clamp_mod(32'(i_d), MOD));
    else if (i_dec)  r_q <= o_is_zero ? W'(MOD - 1) : r_q - W'(1);
  end
endmodule

// File: rtl/countdown_timer.sv
// Three-digit cascaded down-counter with prescaler, IDLE/RUN/DONE control and optional auto-reload.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int MOD0        = DEF_MOD,
  parameter int MOD1        = DEF_MOD,
  parameter int MOD2        = DEF_MOD,
  parameter int TICK_DIV    = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic         enable,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic         borrow0,
  output logic         borrow1,
  output logic         busy,
  output logic         done,
  output logic         expired
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_pre;
  logic [W-1:0]   r_rld0, r_rld1, r_rld2;
  logic [W-1:0]   w_ld0, w_ld1, w_ld2;
  logic           r_b0, r_b1, r_done;
  logic           w_z0, w_z1, w_z2, w_zero;
  logic           w_active, w_tick, w_last, w_reload;
  logic           w_stage_ld, w_dec0, w_b0, w_b1, w_unused_b2, w_done_nxt;

  assign w_zero   = w_z0 && w_z1 && w_z2;
  // Counting starts on the cycle enable is seen in IDLE, so that cycle already spends a prescaler step.
  assign w_active = enable && (r_state == ST_RUN || (r_state == ST_IDLE && !w_zero));
  assign w_tick   = w_active && (r_pre == PW'(TICK_DIV - 1));
  assign w_last   = w_tick && (q0 == W'(1)) && w_z1 && w_z2;
  assign w_reload = w_last && (AUTO_RELOAD != 0) && !load &&
                    ({r_rld2, r_rld1, r_rld0} != '0);

  assign w_stage_ld = load || w_reload;
  assign w_dec0     = w_tick && !load;
  assign w_ld0      = load ? d0 : r_rld0;
  assign w_ld1      = load ? d1 : r_rld1;
  assign w_ld2      = load ? d2 : r_rld2;

  down_stage #(.W(W), .MOD(MOD0)) u_s0 (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_stage_ld), .i_d(w_ld0), .i_dec(w_dec0),
    .o_q(q0), .o_borrow(w_b0), .o_is_zero(w_z0));
  down_stage #(.W(W), .MOD(MOD1)) u_s1 (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_stage_ld), .i_d(w_ld1), .i_dec(w_b0),
    .o_q(q1), .o_borrow(w_b1), .o_is_zero(w_z1));
  // Stage 2 never borrows: the expiry tick stops the chain before 0/0/0 can underflow.
  down_stage #(.W(W), .MOD(MOD2)) u_s2 (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_stage_ld), .i_d(w_ld2), .i_dec(w_b1),
    .o_q(q2), .o_borrow(w_unused_b2), .o_is_zero(w_z2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre  <= '0;
      r_rld0 <= '0;
      r_rld1 <= '0;
      r_rld2 <= '0;
      r_b0   <= 1'b0;
      r_b1   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (load || w_tick) r_pre <= '0;
      else if (w_active)  r_pre <= r_pre + PW'(1);
      if (load) begin
        r_rld0 <= W'(clamp_mod(32'(d0), MOD0));
        r_rld1 <= W'(clamp_mod(32'(d1), MOD1));
        r_rld2 <= W'(clamp_mod(32'(d2), MOD2));
      end
      r_b0   <= w_b0;
      r_b1   <= w_b1;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) w_state_nxt = ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE: if (enable) w_state_nxt = (w_zero || (w_last && !w_reload)) ? ST_DONE : ST_RUN;
        ST_RUN:  if (w_last && !w_reload) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state == ST_RUN);
    expired    = (r_state == ST_DONE);
    w_done_nxt = !load && ((r_state == ST_IDLE && enable && w_zero) || w_last);
  end

  assign borrow0 = r_b0;
  assign borrow1 = r_b1;
  assign done    = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench: three timer configurations share one stimulus stream and are compared to an arithmetic model.
module tb_countdown_timer;
  localparam int TD [3] = '{1, 4, 1};
  localparam int AR [3] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst_n, ld, en;
  logic [6:0] d0, d1, d2;
  logic [6:0] q0w [3];
  logic [6:0] q1w [3];
  logic [6:0] q2w [3];
  logic       b0w [3];
  logic       b1w [3];
  logic       busyw [3];
  logic       donew [3];
  logic       expw [3];

  int total = 0;
  int bad   = 0;

  int m_val [3];
  int m_rld [3];
  int m_pre [3];
  int m_st  [3];   // 0 idle, 1 run, 2 done
  bit m_b0 [3];
  bit m_b1 [3];
  bit m_dn [3];

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(1), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .reset(rst_n), .load(ld), .d0(d0), .d1(d1), .d2(d2), .enable(en),
    .q0(q0w[0]), .q1(q1w[0]), .q2(q2w[0]), .borrow0(b0w[0]), .borrow1(b1w[0]),
    .busy(busyw[0]), .done(donew[0]), .expired(expw[0]));
  countdown_timer #(.TICK_DIV(4), .AUTO_RELOAD(0)) dut_b (
    .clk(clk), .reset(rst_n), .load(ld), .d0(d0), .d1(d1), .d2(d2), .enable(en),
    .q0(q0w[1]), .q1(q1w[1]), .q2(q2w[1]), .borrow0(b0w[1]), .borrow1(b1w[1]),
    .busy(busyw[1]), .done(donew[1]), .expired(expw[1]));
  countdown_timer #(.TICK_DIV(1), .AUTO_RELOAD(1)) dut_c (
    .clk(clk), .reset(rst_n), .load(ld), .d0(d0), .d1(d1), .d2(d2), .enable(en),
    .q0(q0w[2]), .q1(q1w[2]), .q2(q2w[2]), .borrow0(b0w[2]), .borrow1(b1w[2]),
    .busy(busyw[2]), .done(donew[2]), .expired(expw[2]));

  function automatic int cl(int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic logic [25:0] obs(int k);
    return {q2w[k], q1w[k], q0w[k], b0w[k], b1w[k], busyw[k], donew[k], expw[k]};
  endfunction

  function automatic logic [25:0] expv(int k);
    return {7'(m_val[k] / 100 % 10), 7'(m_val[k] / 10 % 10), 7'(m_val[k] % 10),
            m_b0[k], m_b1[k], m_st[k] == 1, m_dn[k], m_st[k] == 2};
  endfunction

  // Timer as a whole number of units: load sets it, each tick subtracts one.
  task automatic step_model();
    for (int k = 0; k < 3; k++) begin
      m_b0[k] = 0; m_b1[k] = 0; m_dn[k] = 0;
      if (!rst_n) begin
        m_val[k] = 0; m_rld[k] = 0; m_pre[k] = 0; m_st[k] = 0;
      end else if (ld) begin
        m_val[k] = cl(int'(d0)) + 10 * cl(int'(d1)) + 100 * cl(int'(d2));
        m_rld[k] = m_val[k]; m_pre[k] = 0; m_st[k] = 0;
      end else if (en && m_st[k] == 0 && m_val[k] == 0) begin
        m_st[k] = 2; m_dn[k] = 1;
      end else if (en && m_st[k] != 2) begin
        m_st[k] = 1;
        if (m_pre[k] == TD[k] - 1) begin
          m_pre[k] = 0;
          if (m_val[k] == 1) begin
            m_dn[k] = 1;
            if (AR[k] != 0 && m_rld[k] != 0) m_val[k] = m_rld[k];
            else begin m_val[k] = 0; m_st[k] = 2; end
          end else begin
            m_b0[k] = (m_val[k] % 10 == 0);
            m_b1[k] = m_b0[k] && (m_val[k] / 10 % 10 == 0);
            m_val[k] = m_val[k] - 1;
          end
        end else m_pre[k] = m_pre[k] + 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    step_model();
    #1;
  endtask

  task automatic set_in(bit r, bit l, int a, int b, int c, bit e);
    rst_n = r; ld = l; d0 = 7'(a); d1 = 7'(b); d2 = 7'(c); en = e;
  endtask

  task automatic test_reset();
    set_in(0, 1, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), 1);
    repeat (2) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin bad++; $display("FAIL reset dut%0d got=%h want=%h", k, obs(k), expv(k)); end
      end
    end
    total++;
    if (obs(0) !== 26'h0) begin bad++; $display("FAIL reset_zero got=%h want=0", obs(0)); end
    set_in(1, 1, 3, 2, 1, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin bad++; $display("FAIL load dut%0d got=%h want=%h", k, obs(k), expv(k)); end
    end
    total++;
    if ({q2w[0], q1w[0], q0w[0], busyw[0], donew[0]} !== {7'd1, 7'd2, 7'd3, 2'b00})
      begin bad++; $display("FAIL load_321 got=%0d/%0d/%0d want=3/2/1", q0w[0], q1w[0], q2w[0]); end
  endtask

  task automatic test_basic();
    set_in(1, 1, 0, 1, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1); cyc();
    total++;
    if ({q1w[0], q0w[0], b0w[0], busyw[0]} !== {7'd0, 7'd9, 2'b11})
      begin bad++; $display("FAIL basic_first got q0=%0d b0=%0d busy=%0d want q0=9 b0=1 busy=1", q0w[0], b0w[0], busyw[0]); end
    repeat (9) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin bad++; $display("FAIL basic dut%0d got=%h want=%h", k, obs(k), expv(k)); end
      end
    end
    total++;
    if ({donew[0], expw[0], q0w[0]} !== {2'b11, 7'd0})
      begin bad++; $display("FAIL basic_expire got done=%0d exp=%0d want 1/1", donew[0], expw[0]); end
    cyc();
    total++;
    if ({donew[0], expw[0]} !== 2'b01) begin bad++; $display("FAIL basic_done_once got done=%0d want=0", donew[0]); end
  endtask

  task automatic test_cascade();
    set_in(1, 1, 0, 0, 1, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1); cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin bad++; $display("FAIL cascade dut%0d got=%h want=%h", k, obs(k), expv(k)); end
    end
    total++;
    if ({q2w[0], q1w[0], q0w[0], b0w[0], b1w[0]} !== {7'd0, 7'd9, 7'd9, 2'b11})
      begin bad++; $display("FAIL cascade_990 got=%0d/%0d/%0d b=%0d%0d want 9/9/0 b=11", q0w[0], q1w[0], q2w[0], b0w[0], b1w[0]); end
  endtask

  task automatic test_clamp_pause();
    set_in(1, 1, 12, 3, 0, 0); cyc();
    total++;
    if (q0w[1] !== 7'd9) begin bad++; $display("FAIL clamp got=%0d want=9", q0w[1]); end
    set_in(1, 0, 0, 0, 0, 1);
    repeat (8) cyc();
    total++;
    if (q0w[1] !== 7'd7) begin bad++; $display("FAIL pre_pause got=%0d want=7", q0w[1]); end
    en = 0;
    repeat (5) begin
      cyc();
      total++;
      if (obs(1) !== expv(1)) begin bad++; $display("FAIL paused got=%h want=%h", obs(1), expv(1)); end
    end
    total++;
    if ({q0w[1], busyw[1]} !== {7'd7, 1'b1}) begin bad++; $display("FAIL pause_hold got q0=%0d busy=%0d want 7/1", q0w[1], busyw[1]); end
    en = 1;
    repeat (3) cyc();
    total++;
    if (q0w[1] !== 7'd7) begin bad++; $display("FAIL resume_early got=%0d want=7", q0w[1]); end
    cyc();
    total++;
    if (q0w[1] !== 7'd6) begin bad++; $display("FAIL resume_tick got=%0d want=6", q0w[1]); end
  endtask

  task automatic test_edges();
    set_in(1, 1, 0, 0, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1); cyc();
    total++;
    if ({donew[0], expw[0], donew[2], expw[2]} !== 4'b1111)
      begin bad++; $display("FAIL zero_load got=%b want=1111", {donew[0], expw[0], donew[2], expw[2]}); end
    cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs(k) !== expv(k)) begin bad++; $display("FAIL zero_hold dut%0d got=%h want=%h", k, obs(k), expv(k)); end
    end
    // load collides with the would-be expiry tick, then with a would-be borrow tick
    set_in(1, 1, 2, 0, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1); cyc();
    set_in(1, 1, 0, 2, 0, 1); cyc();
    total++;
    if ({q1w[0], q0w[0], donew[0], b0w[0], busyw[0]} !== {7'd2, 7'd0, 3'b000})
      begin bad++; $display("FAIL load_vs_done got=%h want=%h", obs(0), expv(0)); end
    set_in(1, 1, 7, 0, 0, 1); cyc();
    total++;
    if ({q1w[0], q0w[0], b0w[0], donew[0]} !== {7'd0, 7'd7, 2'b00})
      begin bad++; $display("FAIL load_vs_borrow got=%h want=%h", obs(0), expv(0)); end
    set_in(1, 1, 0, 5, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 1); repeat (3) cyc();
    rst_n = 0; cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs(k) !== 26'h0) begin bad++; $display("FAIL reset_mid dut%0d got=%h want=0", k, obs(k)); end
    end
  endtask

  task automatic test_autoreload();
    set_in(1, 1, 2, 0, 0, 0); cyc();
    en = 1; ld = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      total++;
      if ({q0w[2], donew[2], busyw[2], expw[2]} !== {(i % 2 == 0) ? 7'd1 : 7'd2, i % 2 == 1, 2'b10})
        begin bad++; $display("FAIL autoreload step%0d got q0=%0d done=%0d busy=%0d exp=%0d", i, q0w[2], donew[2], busyw[2], expw[2]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ld    = ($urandom_range(0, 11) == 0);
      d0 = 7'($urandom_range(0, 15)); d1 = 7'($urandom_range(0, 3)); d2 = 7'($urandom_range(0, 1));
      en    = ($urandom_range(0, 3) != 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs(k) !== expv(k)) begin bad++; $display("FAIL random n=%0d dut%0d got=%h want=%h", n, k, obs(k), expv(k)); end
      end
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_cascade();
    test_clamp_pause();
    test_edges();
    test_autoreload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
